// File: rtl/hpdcache_rr_req_arbiter.sv
// Round-robin valid/ready arbiter for NREQ requesters onto one downstream channel.
// A grant that stalls stays locked until its handshake, so the payload stays stable and no requester starves.

module hpdcache_rr_req_arbiter_lane #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  sel,
    input  logic                  valid,
    input  logic                  down_ready,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  gnt,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data_masked
);
    assign gnt         = sel & valid;
    assign ready       = gnt & down_ready;
    assign data_masked = gnt ? data : '0;
endmodule

module hpdcache_rr_req_arbiter #(
    parameter  int unsigned NREQ       = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_WIDTH  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data_i,
    output logic                       req_valid_o,
    input  logic                       req_ready_i,
    output logic [DATA_WIDTH-1:0]      req_data_o,
    output logic [NREQ-1:0]            req_gnt_o,
    output logic [IDX_WIDTH-1:0]       req_gnt_idx_o
);
    localparam logic [IDX_WIDTH:0] NREQ_W = (IDX_WIDTH+1)'(NREQ);

    logic [IDX_WIDTH-1:0]                ptr_q, ptr_eff, ptr_nxt;
    logic                                lock_q, lock_eff;
    logic [NREQ-1:0]                     gnt_q, rr_gnt, sel;
    logic [IDX_WIDTH:0]                  cand;
    logic                                found;
    logic [NREQ-1:0][DATA_WIDTH-1:0]     data_in, data_masked;

    // While reset is held the outputs already behave as if the state were cleared.
    assign ptr_eff  = rst_i ? '0 : ptr_q;
    assign lock_eff = lock_q & ~rst_i;
    assign data_in  = req_data_i;

    // Cyclic first-valid search starting at ptr_eff; explicit wrap handles non-power-of-2 NREQ.
    always_comb begin
        rr_gnt = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_eff} + (IDX_WIDTH+1)'(k);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && cand == (IDX_WIDTH+1)'(i) && req_valid_i[i]) begin
                    rr_gnt[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

    assign sel = lock_eff ? gnt_q : rr_gnt;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        hpdcache_rr_req_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .sel         (sel[i]),
            .valid       (req_valid_i[i]),
            .down_ready  (req_ready_i),
            .data        (data_in[i]),
            .gnt         (req_gnt_o[i]),
            .ready       (req_ready_o[i]),
            .data_masked (data_masked[i])
        );
    end

    assign req_valid_o = |req_gnt_o;

    always_comb begin
        req_data_o    = '0;
        req_gnt_idx_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data_o = req_data_o | data_masked[i];
            if (req_gnt_o[i]) req_gnt_idx_o = IDX_WIDTH'(i);
        end
    end

    assign ptr_nxt = (req_gnt_idx_o == IDX_WIDTH'(NREQ-1)) ? '0 : req_gnt_idx_o + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            lock_q <= 1'b0;
            gnt_q  <= '0;
        end else if (req_valid_o && !req_ready_i) begin
            lock_q <= 1'b1;
            gnt_q  <= req_gnt_o;
        end else if (req_valid_o) begin
            ptr_q  <= ptr_nxt;
            lock_q <= 1'b0;
        end else begin
            lock_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hpdcache_rr_req_arbiter.sv
// Bench for hpdcache_rr_req_arbiter: directed vector table, NREQ=3 wrap check, randomized run vs. a reference model.
module tb_hpdcache_rr_req_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      valid, ready_o, gnt;
    logic              ready, valid_o;
    logic [N*DW-1:0]   data;
    logic [DW-1:0]     data_o;
    logic [1:0]        idx;

    logic [2:0]        valid3, ready3_o, gnt3;
    logic              ready3, valid3_o;
    logic [3*DW-1:0]   data3;
    logic [DW-1:0]     data3_o;
    logic [1:0]        idx3;

    logic [DW-1:0]     dw [N];

    always #5 clk = ~clk;

    hpdcache_rr_req_arbiter #(.NREQ(N), .DATA_WIDTH(DW)) u4 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready_o),
        .req_data_i(data), .req_valid_o(valid_o), .req_ready_i(ready),
        .req_data_o(data_o), .req_gnt_o(gnt), .req_gnt_idx_o(idx));

    hpdcache_rr_req_arbiter #(.NREQ(3), .DATA_WIDTH(DW)) u3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid3), .req_ready_o(ready3_o),
        .req_data_i(data3), .req_valid_o(valid3_o), .req_ready_i(ready3),
        .req_data_o(data3_o), .req_gnt_o(gnt3), .req_gnt_idx_o(idx3));

    int n_cmp = 0, n_err = 0, n_viol = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pointer, lock flag and locked requester number.
    int  m_ptr = 0, m_lidx = 0;
    bit  m_lock = 0;

    function automatic int model_eval(input bit r, input logic [N-1:0] v);
        int p = r ? 0 : m_ptr;
        bit l = r ? 1'b0 : m_lock;
        if (l) return v[m_lidx] ? m_lidx : -1;
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_update(input bit r, input int g, input bit rdy);
        if (r) begin m_ptr = 0; m_lock = 0; end
        else if (g >= 0 && !rdy) begin m_lock = 1; m_lidx = g; end
        else if (g >= 0) begin m_ptr = (g + 1) % N; m_lock = 0; end
        else m_lock = 0;
    endtask

    bit           prev_stall = 0;
    logic [N-1:0] prev_gnt = '0;

    task automatic monitor();
        chk("onehot", ($countones(gnt) <= 1), 1);
        if (prev_stall && !rst) begin
            if ((prev_gnt & ~valid) != 0) begin
                n_viol++;
                $display("note: protocol violation, locked requester dropped valid (t=%0t)", $time);
            end
            chk("lock_stable", gnt, prev_gnt & valid);
        end
        prev_stall = valid_o && !ready && !rst;
        prev_gnt   = gnt;
    endtask

    task automatic apply(input bit r, input logic [N-1:0] v, input bit rdy);
        @(negedge clk);
        rst = r; valid = v; ready = rdy;
        for (int i = 0; i < N; i++) data[i*DW +: DW] = dw[i];
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [N-1:0] eg, input int eidx);
        chk({tag, "_gnt"},   gnt, eg);
        chk({tag, "_idx"},   idx, eidx);
        chk({tag, "_valid"}, valid_o, |eg);
        chk({tag, "_ready"}, ready_o, eg & {N{ready}});
        chk({tag, "_data"},  data_o, (eg == 0) ? '0 : dw[eidx]);
    endtask

    typedef struct {
        bit           r;
        logic [N-1:0] v;
        bit           rdy;
        logic [N-1:0] eg;
        int           eidx;
    } vec_t;

    vec_t tbl [24];

    initial begin
        int g;
        logic [N-1:0] pending, v;
        bit r, rdy;

        rst = 1; valid = '0; ready = 0; data = '0;
        valid3 = '0; ready3 = 1; data3 = '0;
        for (int i = 0; i < N; i++) dw[i] = 32'hC0DE_0000 + 32'h1111 * (i + 1);

        tbl[0]  = '{1, 4'b0000, 1, 4'b0000, 0};
        tbl[1]  = '{1, 4'b1111, 1, 4'b0001, 0};
        tbl[2]  = '{0, 4'b1111, 1, 4'b0001, 0};
        tbl[3]  = '{0, 4'b1111, 1, 4'b0010, 1};
        tbl[4]  = '{0, 4'b1111, 1, 4'b0100, 2};
        tbl[5]  = '{0, 4'b1111, 1, 4'b1000, 3};
        tbl[6]  = '{0, 4'b1111, 1, 4'b0001, 0};
        tbl[7]  = '{0, 4'b1111, 1, 4'b0010, 1};
        tbl[8]  = '{0, 4'b0100, 0, 4'b0100, 2};
        tbl[9]  = '{0, 4'b0101, 0, 4'b0100, 2};
        tbl[10] = '{0, 4'b0101, 0, 4'b0100, 2};
        tbl[11] = '{0, 4'b0101, 1, 4'b0100, 2};
        tbl[12] = '{0, 4'b0001, 1, 4'b0001, 0};
        tbl[13] = '{0, 4'b0100, 1, 4'b0100, 2};
        tbl[14] = '{0, 4'b0011, 1, 4'b0001, 0};
        tbl[15] = '{0, 4'b0011, 1, 4'b0010, 1};
        tbl[16] = '{0, 4'b0011, 1, 4'b0001, 0};
        tbl[17] = '{0, 4'b1000, 0, 4'b1000, 3};
        tbl[18] = '{1, 4'b1111, 0, 4'b0001, 0};
        tbl[19] = '{0, 4'b1111, 1, 4'b0001, 0};
        tbl[20] = '{0, 4'b0010, 0, 4'b0010, 1};
        tbl[21] = '{0, 4'b1000, 0, 4'b0000, 0};
        tbl[22] = '{0, 4'b1000, 1, 4'b1000, 3};
        tbl[23] = '{0, 4'b0000, 1, 4'b0000, 0};

        foreach (tbl[n]) begin
            apply(tbl[n].r, tbl[n].v, tbl[n].rdy);
            check_outputs($sformatf("tbl%0d", n), tbl[n].eg, tbl[n].eidx);
            monitor();
            model_update(tbl[n].r, model_eval(tbl[n].r, tbl[n].v), tbl[n].rdy);
        end
        chk("proto_viol_seen", n_viol, 1);

        // NREQ=3: non-power-of-2 wrap, all valid, ready high
        for (int i = 0; i < 3; i++) data3[i*DW +: DW] = 32'hBEEF_0000 + i;
        @(negedge clk); rst = 1; valid = '0; valid3 = '0;
        @(negedge clk); rst = 0; valid3 = 3'b111; #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("n3_idx%0d", c), idx3, c % 3);
            chk($sformatf("n3_gnt%0d", c), gnt3, 3'b001 << (c % 3));
            chk($sformatf("n3_data%0d", c), data3_o, 32'hBEEF_0000 + (c % 3));
            @(negedge clk); #1;
        end
        valid3 = '0;

        // Randomized run against the model; requesters honour the hold-until-handshake rule.
        apply(1, '0, 1);
        monitor();
        model_update(1, -1, 1);
        pending = '0;
        for (int c = 0; c < 400; c++) begin
            r   = ($urandom_range(0, 49) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            v   = pending | 4'($urandom);
            for (int i = 0; i < N; i++) if (!pending[i]) dw[i] = $urandom;
            apply(r, v, rdy);
            g = model_eval(r, v);
            check_outputs("rnd", (g < 0) ? 4'b0000 : 4'(1 << g), (g < 0) ? 0 : g);
            monitor();
            model_update(r, g, rdy);
            pending = v & ~ready_o;
        end
        chk("no_extra_viol", n_viol, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
